// File: rtl/spi_slave.sv
// SPI mode-0 slave with a 16 x 32 register file: 8-bit command, 24-bit address, 32-bit data per frame.
// Optional build macro SPI_SLAVE_ADDR_CHECK_EN rejects addresses with nonzero bits [23:4].
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        busy,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
  localparam logic [7:0]  CMD_WR   = 8'h02;
  localparam logic [7:0]  CMD_RD   = 8'h03;
  localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

  logic        sclk_s1, sclk_s2, sclk_d;
  logic        cs_s1, cs_s2, cs_d;
  logic        mosi_s1, mosi_s2;
  logic [1:0]  sync_cnt;
  logic        armed;
  state_t      state;
  logic [5:0]  bit_cnt;
  logic [30:0] rx_shift;
  logic [30:0] tx_shift;
  logic        tx_loaded;
  logic [7:0]  cmd;
  logic [3:0]  addr_idx;
  logic        addr_bad;
  logic [31:0] mem [16];

  logic        sclk_rise, sclk_fall, cs_fall, addr_bad_nxt;
  logic [31:0] rx_word, tx_word;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  // A falling cs_n only counts once a genuine high level has been seen after reset.
  assign cs_fall   = ~cs_s2 & cs_d & armed;
  assign rx_word   = {rx_shift, mosi_s2};
  assign tx_word   = addr_bad ? BAD_WORD : mem[addr_idx];

`ifdef SPI_SLAVE_ADDR_CHECK_EN
  assign addr_bad_nxt = |rx_word[23:4];
`else
  assign addr_bad_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_d    <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_d      <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      sync_cnt  <= '0;
      armed     <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_loaded <= 1'b0;
      cmd       <= '0;
      addr_idx  <= '0;
      addr_bad  <= 1'b0;
      miso      <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      // cs_s2 reflects the pin only after the reset values have flushed out.
      if (sync_cnt != 2'd3) sync_cnt <= sync_cnt + 2'd1;
      if (sync_cnt == 2'd3 && cs_s2) armed <= 1'b1;

      wr_strobe <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state   <= CMD;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        DONE: begin
          miso <= 1'b0;
          if (cs_s2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (cs_s2) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso      <= 1'b0;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= rx_word[30:0];
            bit_cnt  <= bit_cnt + 6'd1;
            if (state == CMD && bit_cnt == 6'd7) begin
              cmd   <= rx_word[7:0];
              state <= ADDR;
            end
            if (state == ADDR && bit_cnt == 6'd31) begin
              addr_idx  <= rx_word[3:0];
              addr_bad  <= addr_bad_nxt;
              tx_loaded <= 1'b0;
              state     <= DATA;
            end
            if (state == DATA && bit_cnt == 6'd63) begin
              state <= DONE;
              miso  <= 1'b0;
              if (cmd == CMD_WR && !addr_bad) begin
                mem[addr_idx] <= rx_word;
                wr_strobe     <= 1'b1;
                wr_addr       <= addr_idx;
                wr_data       <= rx_word;
              end else if (cmd != CMD_RD || addr_bad) begin
                frame_err <= 1'b1;
              end
            end
          end else if (sclk_fall && state == DATA && cmd == CMD_RD) begin
            if (!tx_loaded) begin
              tx_loaded <= 1'b1;
              miso      <= tx_word[31];
              tx_shift  <= tx_word[30:0];
            end else begin
              miso      <= tx_shift[30];
              tx_shift  <= {tx_shift[29:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frames then random frames scored against a word-level memory model.
module tb_spi_slave;
  logic        clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, busy, wr_strobe, frame_err;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0, errors = 0;
  int n_strobe = 0, n_err = 0;
  logic [31:0] mem_m [16];
  logic [3:0]  last_addr;
  logic [31:0] last_data;

`ifdef SPI_SLAVE_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe <= n_strobe + 1;
    if (frame_err === 1'b1) n_err <= n_err + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic in_range(input logic [23:0] a);
    return !ADDR_CHECK || (a[23:4] == 20'd0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    last_addr = '0;
    last_data = '0;
  endtask

  // Master side: drive mosi half a period before each rising edge, sample miso on it.
  task automatic shift(input logic [63:0] f, input int from, input int to, output logic [31:0] rd);
    rd = '0;
    for (int i = from; i < to; i++) begin
      mosi = f[63-i];
      tick(8);
      sclk = 1'b1;
      if (i >= 32) rd[63-i] = miso;
      tick(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                       input int nbits, input string tag);
    logic [31:0] rd;
    int s0, e0, exp_s, exp_e;
    logic [3:0] idx;
    logic inr;
    s0 = n_strobe;
    e0 = n_err;
    cs_n = 1'b0;
    tick(6);
    check({tag, ":busy_hi"}, busy, 1);
    shift({c, a, d}, 0, nbits, rd);
    tick(8);
    cs_n = 1'b1;
    tick(10);
    check({tag, ":busy_lo"}, busy, 0);
    check({tag, ":miso_idle"}, miso, 0);

    idx = a[3:0];
    inr = in_range(a);
    exp_s = 0;
    exp_e = 0;
    if (nbits < 64) exp_e = 1;
    else if (c == 8'h02) begin
      if (inr) begin
        exp_s = 1;
        mem_m[idx] = d;
        last_addr = idx;
        last_data = d;
      end else exp_e = 1;
    end else if (c == 8'h03) begin
      check({tag, ":rd_data"}, rd, inr ? mem_m[idx] : 32'hDEAD_BEEF);
      exp_e = inr ? 0 : 1;
    end else begin
      exp_e = 1;
      check({tag, ":miso_zero"}, rd, 0);
    end
    check({tag, ":strobes"}, n_strobe - s0, exp_s);
    check({tag, ":errs"}, n_err - e0, exp_e);
    check({tag, ":wr_addr"}, wr_addr, last_addr);
    check({tag, ":wr_data"}, wr_data, last_data);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  c;
    logic [23:0] a;
    int s0, e0, r, nb;

    model_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    check("rst:miso", miso, 0);
    check("rst:busy", busy, 0);
    check("rst:wr_strobe", wr_strobe, 0);
    check("rst:wr_addr", wr_addr, 0);
    check("rst:wr_data", wr_data, 0);
    check("rst:frame_err", frame_err, 0);

    frame(8'h03, 24'h000005, 32'h0, 64, "rd5_after_reset");
    frame(8'h02, 24'h000003, 32'h789ABCDE, 64, "wr3");
    frame(8'h03, 24'h000003, 32'h0, 64, "rd3");
    frame(8'h02, 24'h000001, 32'h12345678, 40, "wr1_abort");
    frame(8'h03, 24'h000001, 32'h0, 64, "rd1_after_abort");
    frame(8'hA5, 24'h000003, 32'hFFFF0000, 64, "cmd_a5");
    frame(8'h03, 24'h000003, 32'h0, 64, "rd3_after_a5");
    frame(8'h02, 24'h000013, 32'hCAFEF00D, 64, "wr13");
    frame(8'h03, 24'h000013, 32'h0, 64, "rd13");
    frame(8'h03, 24'h000003, 32'h0, 64, "rd3_after_wr13");
    frame(8'h02, 24'h00000F, 32'hA5A5_5A5A, 64, "wr15");
    frame(8'h03, 24'h00000F, 32'h0, 64, "rd15_back_to_back");

    // Reset mid-frame with cs_n held low: no write, no error, memory cleared.
    cs_n = 1'b0;
    tick(6);
    shift({8'h02, 24'h000007, 32'h11112222}, 0, 20, rd);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    model_reset();
    s0 = n_strobe;
    e0 = n_err;
    check("midrst:busy", busy, 0);
    check("midrst:wr_addr", wr_addr, 0);
    check("midrst:wr_data", wr_data, 0);
    shift({8'h02, 24'h000007, 32'h11112222}, 20, 64, rd);
    tick(8);
    cs_n = 1'b1;
    tick(10);
    check("midrst:strobes", n_strobe - s0, 0);
    check("midrst:errs", n_err - e0, 0);
    frame(8'h03, 24'h000007, 32'h0, 64, "rd7_after_midrst");
    frame(8'h03, 24'h00000F, 32'h0, 64, "rd15_cleared");

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) c = 8'h02;
      else if (r < 8) c = 8'h03;
      else begin
        c = 8'($urandom);
        if (c == 8'h02 || c == 8'h03) c = c ^ 8'h80;
      end
      a  = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 15));
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 63) : 64;
      frame(c, a, $urandom, nb, $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-low (rst=0 resets on next clk rising edge).
REQ-003 SHALL: sclk  input  1  SPI serial clock from master, asynchronous to clk, f_sclk <= f_clk/4.
REQ-004 SHALL: cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-005 SHALL: mosi  input  1  serial data from master, MSB first.
REQ-006 SHALL: miso  output  1  serial data to master, MSB first; 0 when not driving read data.
REQ-007 SHALL: busy  output  1  high while a frame is in progress (cs_n low after sync).
REQ-008 SHALL: wr_strobe  output  1  one-clk pulse when a write frame commits to memory.
REQ-009 SHALL: wr_addr  output  4  word index of the last committed write.
REQ-010 SHALL: wr_data  output  32  data of the last committed write.
REQ-011 SHALL: frame_err  output  1  one-clk pulse on aborted frame or unknown command.

Function
REQ-012 SHALL: sclk, cs_n, mosi pass through 2-flop synchronisers; sclk edges detected from synchronised history.
REQ-013 SHALL: SPI mode 0: mosi sampled on sclk rising edge, miso updated on sclk falling edge.
REQ-014 SHALL: frame = 8-bit command, 24-bit address, 32-bit data (64 sclk cycles), MSB first.
REQ-015 SHALL: FSM states IDLE, CMD, ADDR, DATA, DONE; 6-bit bit counter.
REQ-016 SHALL: IDLE->CMD on synchronised cs_n falling edge; CMD->ADDR after 8 rising edges; ADDR->DATA after 24; DATA->DONE after 32; DONE->IDLE on cs_n high.
REQ-017 SHALL: internal memory 16 x 32 bits, indexed by address bits [3:0]; address bits [23:4] ignored unless REQ-030 applies.
REQ-018 SHALL: command 8'h02 = write; at DATA->DONE, memory[addr[3:0]] <= received word; wr_strobe, wr_addr, wr_data update same clk.
REQ-019 SHALL: command 8'h03 = read; memory word loaded into transmit shifter on the first sclk falling edge after the 32nd rising edge, bit 31 on miso; each later falling edge shifts next bit.
REQ-020 SHALL: any other command: data phase received and discarded, no write, miso 0, frame_err pulse at DATA->DONE.
REQ-021 SHALL: cs_n high before DONE: abort to IDLE, no memory write, no wr_strobe, frame_err pulse one clk later.
REQ-022 SHALL: sclk edges in DONE (beyond 64) ignored; miso 0.
REQ-023 SHALL: miso 0 whenever synchronised cs_n high or state not DATA during read.
REQ-024 SHALL: write then read to same index in consecutive frames returns new value.

Reset
REQ-025 SHALL: on rst=0 at clk edge: state IDLE, bit counter 0, shifters 0, miso 0, busy 0, wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0, synchronisers to idle (cs_n=1, sclk=0).
REQ-026 SHALL: memory contents cleared to 0 on reset.
REQ-027 SHALL: reset mid-frame aborts without write or frame_err; next frame requires fresh cs_n falling edge.

Configuration
REQ-028 SHALL: macro SPI_SLAVE_ADDR_CHECK_EN selects address range checking.
REQ-029 SHALL: without macro: address bits [23:4] ignored, aliasing every 16 words.
REQ-030 SHALL: with macro: address with bits [23:4] nonzero -> write discarded (no wr_strobe), read returns 32'hDEAD_BEEF, frame_err pulse at DATA->DONE.

Verification
REQ-031 SHALL: write frame 02/000003/789ABCDE -> wr_strobe once, wr_addr=3, wr_data=32'h789ABCDE.
REQ-032 SHALL: read frame 03/000003 after REQ-031 -> miso shifts 32'h789ABCDE MSB first during data phase.
REQ-033 SHALL: read frame 03/000005 after reset -> miso returns 32'h00000000.
REQ-034 SHALL: write frame 02/000001/12345678 with cs_n raised after 40 bits -> no wr_strobe, frame_err pulse, read of index 1 returns 0.
REQ-035 SHALL: command 8'hA5 full frame -> frame_err pulse, memory unchanged.
REQ-036 SHALL: write 02/000013/CAFEF00D -> without macro writes index 3; with SPI_SLAVE_ADDR_CHECK_EN no write, frame_err pulse, read 03/000013 returns 32'hDEADBEEF.
